mf_frame_ctrl: RTL and testbench

MF_FRAME_CTRL -- requirements
Module: mf_frame_ctrl

---
 rtl/mf_ctrl_pkg.sv | 20 ++
 rtl/mf_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mf_frame_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mf_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mf_ctrl_pkg
// Shared definitions for the median-filter frame controller.
//   state_t        : frame-tracking FSM states
//   ERR_*          : bit positions inside the sticky error vector err_o
// ---------------------------------------------------------------------------
package mf_ctrl_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  localparam int ERR_W           = 4;
  localparam int ERR_SHORT_LINE  = 0;
  localparam int ERR_LONG_LINE   = 1;
  localparam int ERR_SHORT_FRAME = 2;
  localparam int ERR_LONG_FRAME  = 3;

endpackage

// File: rtl/mf_frame_ctrl.sv
// ---------------------------------------------------------------------------
// mf_frame_ctrl
// Watches the filter input stream and latches the CSR filter enable only at
// start of frame, so the filter never switches mode mid-frame. Also counts
// completed frames and (optionally) flags malformed geometry.
//
// Parameters
//   FRAME_RES_X     active pixels per line (>=2)
//   FRAME_RES_Y     active lines per frame (>=2)
//   FRAME_CNT_WIDTH width of the completed-frame counter
//
// Ports
//   clk_i         clock
//   rst_i         asynchronous active-high reset
//   cfg_en_i      requested filter enable (level)
//   mon_t*_i      tap of the filter input AXI-Stream handshake/sideband
//   err_clr_i     single-cycle clear of sticky errors
//   mf_en_o       frame-aligned filter enable
//   busy_o        high while a frame is in progress
//   frame_cnt_o   completed-frame count (wraps)
//   err_o         sticky errors {long_frame, short_frame, long_line, short_line}
//
// Build option
//   MF_FRAME_CTRL_ERR_EN : when defined, geometry checking drives err_o;
//                          otherwise err_o is tied to zero.
// ---------------------------------------------------------------------------
module mf_frame_ctrl
  import mf_ctrl_pkg::*;
#(
  parameter int FRAME_RES_X     = 1920,
  parameter int FRAME_RES_Y     = 1080,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cfg_en_i,
  input  logic                       mon_tvalid_i,
  input  logic                       mon_tready_i,
  input  logic                       mon_tuser_i,
  input  logic                       mon_tlast_i,
  input  logic                       err_clr_i,
  output logic                       mf_en_o,
  output logic                       busy_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o,
  output logic [ERR_W-1:0]           err_o
);

  localparam int XW = $clog2(FRAME_RES_X + 1);
  localparam int YW = $clog2(FRAME_RES_Y + 1);

  localparam logic [XW-1:0] RES_X   = XW'(FRAME_RES_X);
  localparam logic [XW:0]   RES_X_W = (XW+1)'(FRAME_RES_X);
  localparam logic [YW-1:0] RES_Y   = YW'(FRAME_RES_Y);
  localparam logic [YW:0]   RES_Y_W = (YW+1)'(FRAME_RES_Y);

  state_t                     state_q, state_d;
  logic [XW-1:0]              x_q, x_d;
  logic [YW-1:0]              y_q, y_d;
  logic                       mf_en_q, mf_en_d;
  logic                       busy_q;
  logic [FRAME_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [XW:0]                x_inc;
  logic [YW:0]                y_inc;
  logic                       beat;

  assign beat  = mon_tvalid_i & mon_tready_i;
  assign x_inc = {1'b0, x_q} + (XW+1)'(1);
  assign y_inc = {1'b0, y_q} + (YW+1)'(1);

`ifdef MF_FRAME_CTRL_ERR_EN
  logic [ERR_W-1:0] err_set;
  logic [ERR_W-1:0] err_q;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mf_en_d = mf_en_q;
    cnt_d   = cnt_q;
`ifdef MF_FRAME_CTRL_ERR_EN
    err_set = '0;
`endif
    if (beat) begin
      if (mon_tuser_i) begin
        // Any SOF restarts the frame; one seen while ACTIVE truncates the
        // previous frame, which is then not counted.
`ifdef MF_FRAME_CTRL_ERR_EN
        if (state_q == ACTIVE) err_set[ERR_SHORT_FRAME] = 1'b1;
`endif
        mf_en_d = cfg_en_i;
        state_d = ACTIVE;
        if (mon_tlast_i) begin
          // SOF and EOL together: a 1-pixel line, always short since X>=2,
          // and never the last line since Y>=2.
`ifdef MF_FRAME_CTRL_ERR_EN
          err_set[ERR_SHORT_LINE] = 1'b1;
`endif
          x_d = '0;
          y_d = YW'(1);
        end else begin
          x_d = XW'(1);
          y_d = '0;
        end
      end else if (state_q == ACTIVE) begin
        if (!mon_tlast_i) begin
          if (x_q == RES_X) begin
`ifdef MF_FRAME_CTRL_ERR_EN
            err_set[ERR_LONG_LINE] = 1'b1;
`endif
          end else begin
            x_d = x_inc[XW-1:0];
          end
        end else begin
`ifdef MF_FRAME_CTRL_ERR_EN
          if (x_inc < RES_X_W) err_set[ERR_SHORT_LINE] = 1'b1;
          if (x_inc > RES_X_W) err_set[ERR_LONG_LINE]  = 1'b1;
          if (y_q >= RES_Y)    err_set[ERR_LONG_FRAME] = 1'b1;
`endif
          x_d = '0;
          if (y_inc == RES_Y_W) begin
            cnt_d   = cnt_q + FRAME_CNT_WIDTH'(1);
            state_d = WAIT_SOF;
            y_d     = y_inc[YW-1:0];
          end else if (y_q != RES_Y) begin
            // Saturate so the defensive long_frame path cannot wrap y.
            y_d = y_inc[YW-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WAIT_SOF;
      x_q     <= '0;
      y_q     <= '0;
      mf_en_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mf_en_q <= mf_en_d;
      busy_q  <= (state_d == ACTIVE);
      cnt_q   <= cnt_d;
    end
  end

`ifdef MF_FRAME_CTRL_ERR_EN
  // New events win over a coincident clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= '0;
    end else begin
      err_q <= (err_clr_i ? '0 : err_q) | err_set;
    end
  end

  assign err_o = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_o          = '0;
`endif

  assign mf_en_o     = mf_en_q;
  assign busy_o      = busy_q;
  assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_mf_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mf_frame_ctrl
// Directed self-checking bench for mf_frame_ctrl with a 4x3 frame geometry.
// Expected error values are masked to zero when MF_FRAME_CTRL_ERR_EN is not
// defined, since err_o is then tied off.
// ---------------------------------------------------------------------------
module tb_mf_frame_ctrl;

  localparam int RX = 4;
  localparam int RY = 3;
  localparam int CW = 16;

`ifdef MF_FRAME_CTRL_ERR_EN
  localparam logic [3:0] ERR_MASK = 4'b1111;
`else
  localparam logic [3:0] ERR_MASK = 4'b0000;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cfg_en_i = 1'b0;
  logic          mon_tvalid_i = 1'b0;
  logic          mon_tready_i = 1'b0;
  logic          mon_tuser_i = 1'b0;
  logic          mon_tlast_i = 1'b0;
  logic          err_clr_i = 1'b0;
  logic          mf_en_o;
  logic          busy_o;
  logic [CW-1:0] frame_cnt_o;
  logic [3:0]    err_o;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [3:0]    exp_err;

  mf_frame_ctrl #(
    .FRAME_RES_X    (RX),
    .FRAME_RES_Y    (RY),
    .FRAME_CNT_WIDTH(CW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_en_i    (cfg_en_i),
    .mon_tvalid_i(mon_tvalid_i),
    .mon_tready_i(mon_tready_i),
    .mon_tuser_i (mon_tuser_i),
    .mon_tlast_i (mon_tlast_i),
    .err_clr_i   (err_clr_i),
    .mf_en_o     (mf_en_o),
    .busy_o      (busy_o),
    .frame_cnt_o (frame_cnt_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  // One handshake beat; returns 1 time unit after the capturing edge.
  task automatic beat(input logic u, input logic l);
    mon_tvalid_i = 1'b1;
    mon_tready_i = 1'b1;
    mon_tuser_i  = u;
    mon_tlast_i  = l;
    @(posedge clk_i);
    #1;
    mon_tvalid_i = 1'b0;
    mon_tready_i = 1'b0;
    mon_tuser_i  = 1'b0;
    mon_tlast_i  = 1'b0;
  endtask

  task automatic clean_line();
    repeat (RX - 1) beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
  endtask

  task automatic clean_frame();
    beat(1'b1, 1'b0);
    repeat (RX - 2) beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    repeat (RY - 1) clean_line();
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_chk++; if (mf_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_mf_en: got %b want 0", mf_en_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_chk++; if (frame_cnt_o !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt_o); end
    n_chk++; if (err_o !== 4'b0000) begin n_fail++; $display("FAIL reset_err: got %b want 0000", err_o); end
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_clean_frames();
    cfg_en_i = 1'b1;
    beat(1'b1, 1'b0);
    n_chk++; if (mf_en_o !== 1'b1) begin n_fail++; $display("FAIL clean_mf_en_sof: got %b want 1", mf_en_o); end
    n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL clean_busy_sof: got %b want 1", busy_o); end
    repeat (RX - 2) beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    repeat (RY - 1) clean_line();
    exp_cnt = exp_cnt + 1'b1;
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL clean_busy_gap: got %b want 0", busy_o); end
    n_chk++; if (frame_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL clean_cnt1: got %0d want %0d", frame_cnt_o, exp_cnt); end
    // Stray non-SOF beats between frames are ignored.
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL gap_beats_busy: got %b want 0", busy_o); end
    clean_frame();
    exp_cnt = exp_cnt + 1'b1;
    n_chk++; if (frame_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL clean_cnt2: got %0d want %0d", frame_cnt_o, exp_cnt); end
    n_chk++; if (err_o !== 4'b0000) begin n_fail++; $display("FAIL clean_err: got %b want 0000", err_o); end
    n_chk++; if (mf_en_o !== 1'b1) begin n_fail++; $display("FAIL clean_mf_en_end: got %b want 1", mf_en_o); end
  endtask

  task automatic test_handshake();
    // Valid without ready is not a beat.
    mon_tvalid_i = 1'b1;
    mon_tready_i = 1'b0;
    mon_tuser_i  = 1'b1;
    @(posedge clk_i);
    #1;
    mon_tvalid_i = 1'b0;
    mon_tuser_i  = 1'b0;
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL nohs_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_cfg_toggle();
    cfg_en_i = 1'b1;
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    cfg_en_i = 1'b0;
    beat(1'b0, 1'b0);
    n_chk++; if (mf_en_o !== 1'b1) begin n_fail++; $display("FAIL cfg_mid_frame: got %b want 1", mf_en_o); end
    beat(1'b0, 1'b1);
    repeat (RY - 1) clean_line();
    exp_cnt = exp_cnt + 1'b1;
    n_chk++; if (mf_en_o !== 1'b1) begin n_fail++; $display("FAIL cfg_after_frame: got %b want 1", mf_en_o); end
    beat(1'b1, 1'b0);
    n_chk++; if (mf_en_o !== 1'b0) begin n_fail++; $display("FAIL cfg_next_sof: got %b want 0", mf_en_o); end
    repeat (RX - 2) beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    repeat (RY - 1) clean_line();
    exp_cnt = exp_cnt + 1'b1;
    n_chk++; if (frame_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL cfg_cnt: got %0d want %0d", frame_cnt_o, exp_cnt); end
    cfg_en_i = 1'b1;
  endtask

  task automatic test_line_errors();
    // Line 0: tlast on the 3rd pixel.
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    exp_err = 4'b0001 & ERR_MASK;
    n_chk++; if (err_o !== exp_err) begin n_fail++; $display("FAIL short_line: got %b want %b", err_o, exp_err); end
    pulse_clr();
    n_chk++; if (err_o !== 4'b0000) begin n_fail++; $display("FAIL clr_alone: got %b want 0000", err_o); end
    // Line 1: six pixels.
    repeat (5) beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    exp_err = 4'b0010 & ERR_MASK;
    n_chk++; if (err_o !== exp_err) begin n_fail++; $display("FAIL long_line: got %b want %b", err_o, exp_err); end
    clean_line();
    exp_cnt = exp_cnt + 1'b1;
    n_chk++; if (frame_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL line_err_cnt: got %0d want %0d", frame_cnt_o, exp_cnt); end
    pulse_clr();
  endtask

  task automatic test_short_frame();
    beat(1'b1, 1'b0);
    repeat (RX - 2) beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    clean_line();
    beat(1'b1, 1'b0);
    exp_err = 4'b0100 & ERR_MASK;
    n_chk++; if (err_o !== exp_err) begin n_fail++; $display("FAIL short_frame_err: got %b want %b", err_o, exp_err); end
    n_chk++; if (frame_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL short_frame_cnt: got %0d want %0d", frame_cnt_o, exp_cnt); end
    n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL short_frame_busy: got %b want 1", busy_o); end
    repeat (RX - 2) beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    repeat (RY - 1) clean_line();
    exp_cnt = exp_cnt + 1'b1;
    n_chk++; if (frame_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL restart_cnt: got %0d want %0d", frame_cnt_o, exp_cnt); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL restart_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_clr_coincide();
    // short_frame from the previous test is still set; a clear coinciding
    // with a short-line event leaves only the new bit.
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    err_clr_i = 1'b1;
    beat(1'b0, 1'b1);
    err_clr_i = 1'b0;
    exp_err = 4'b0001 & ERR_MASK;
    n_chk++; if (err_o !== exp_err) begin n_fail++; $display("FAIL clr_coincide: got %b want %b", err_o, exp_err); end
    repeat (RY - 1) clean_line();
    exp_cnt = exp_cnt + 1'b1;
    pulse_clr();
    n_chk++; if (err_o !== 4'b0000) begin n_fail++; $display("FAIL clr_after: got %b want 0000", err_o); end
  endtask

  task automatic test_sof_eol();
    cfg_en_i = 1'b0;
    beat(1'b1, 1'b1);
    exp_err = 4'b0001 & ERR_MASK;
    n_chk++; if (err_o !== exp_err) begin n_fail++; $display("FAIL sof_eol_err: got %b want %b", err_o, exp_err); end
    n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL sof_eol_busy: got %b want 1", busy_o); end
    n_chk++; if (mf_en_o !== 1'b0) begin n_fail++; $display("FAIL sof_eol_mf_en: got %b want 0", mf_en_o); end
    repeat (RY - 1) clean_line();
    exp_cnt = exp_cnt + 1'b1;
    n_chk++; if (frame_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL sof_eol_cnt: got %0d want %0d", frame_cnt_o, exp_cnt); end
    cfg_en_i = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    n_chk++; if (mf_en_o !== 1'b0) begin n_fail++; $display("FAIL async_rst_mf_en: got %b want 0", mf_en_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy: got %b want 0", busy_o); end
    n_chk++; if (frame_cnt_o !== '0) begin n_fail++; $display("FAIL async_rst_cnt: got %0d want 0", frame_cnt_o); end
    n_chk++; if (err_o !== 4'b0000) begin n_fail++; $display("FAIL async_rst_err: got %b want 0000", err_o); end
    exp_cnt = '0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_ignore: got %b want 0", busy_o); end
    clean_frame();
    exp_cnt = exp_cnt + 1'b1;
    n_chk++; if (frame_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL post_rst_cnt: got %0d want %0d", frame_cnt_o, exp_cnt); end
    n_chk++; if (err_o !== 4'b0000) begin n_fail++; $display("FAIL post_rst_err: got %b want 0000", err_o); end
    n_chk++; if (mf_en_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_mf_en: got %b want 1", mf_en_o); end
  endtask

  initial begin
    test_reset();
    test_clean_frames();
    test_handshake();
    test_cfg_toggle();
    test_line_errors();
    test_short_frame();
    test_clr_coincide();
    test_sof_eol();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
